// File: rtl/upsp_frame_ctrl.sv
// Frame sequencer between access_control and bicubic_top: gates pixel handshakes,
// counts a frame in and out, and posts completion or timeout status to UPENDR.
module upsp_frame_ctrl #(
  parameter int CRF_DATA_WIDTH = 32,
  parameter int CRF_ADDR_WIDTH = 32,
  parameter int SRC_IMG_WIDTH  = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160,
  parameter int UPENDR_ADDR    = 'h4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  input  logic                      src_valid_i,
  output logic                      src_valid_o,
  input  logic                      src_rd_i,
  input  logic                      dst_wrt_i,
  input  logic                      dst_wready_i,
  output logic                      dst_wready_o,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam int SXW = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
  localparam int SYW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam int DXW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int DYW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]     state_q, state_d;
  logic           err_q, err_d;
  logic           upstr_q;
  logic [SXW-1:0] src_x_q;
  logic [SYW-1:0] src_y_q;
  logic [DXW-1:0] dst_x_q;
  logic [DYW-1:0] dst_y_q;
  logic [WDW-1:0] wd_q;

  logic start, active, src_hs, dst_hs, src_last, dst_last, timeout, wr_done;
  logic unused_upstr;

  assign unused_upstr = ^crf_ac_UPSTR[CRF_DATA_WIDTH-1:1];

  assign active       = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign src_valid_o  = src_valid_i & (state_q == S_RUN);
  assign dst_wready_o = dst_wready_i & active;
  assign src_hs       = src_valid_o & src_rd_i;
  assign dst_hs       = dst_wrt_i & dst_wready_o;
  assign start        = crf_ac_UPSTR[0] & ~upstr_q;

  assign src_last = (src_x_q == SXW'(SRC_IMG_WIDTH - 1)) & (src_y_q == SYW'(SRC_IMG_HEIGHT - 1));
  assign dst_last = (dst_x_q == DXW'(DST_IMG_WIDTH - 1)) & (dst_y_q == DYW'(DST_IMG_HEIGHT - 1));
  // A beat in the expiry cycle resets the watchdog, so a final beat there completes cleanly.
  assign timeout  = active & ~dst_hs & (wd_q == WDW'(TIMEOUT_CYCLES - 1));
  assign wr_done  = (state_q == S_REPORT) & ~crf_ac_wbusy;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (dst_hs & dst_last)      state_d = S_REPORT;
        else if (timeout) begin
          state_d = S_REPORT;
          err_d   = 1'b1;
        end
        else if (src_hs & src_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (dst_hs & dst_last) state_d = S_REPORT;
        else if (timeout) begin
          state_d = S_REPORT;
          err_d   = 1'b1;
        end
      end
      default: begin
        if (!crf_ac_wbusy) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      upstr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      upstr_q <= crf_ac_UPSTR[0];
    end
  end

  // Counters freeze on the last pixel so the final position stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_x_q <= '0;
      src_y_q <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
      wd_q    <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      src_x_q <= '0;
      src_y_q <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
      wd_q    <= '0;
    end else begin
      if (src_hs && !src_last) begin
        if (src_x_q == SXW'(SRC_IMG_WIDTH - 1)) begin
          src_x_q <= '0;
          src_y_q <= src_y_q + 1'b1;
        end else begin
          src_x_q <= src_x_q + 1'b1;
        end
      end
      if (dst_hs && !dst_last) begin
        if (dst_x_q == DXW'(DST_IMG_WIDTH - 1)) begin
          dst_x_q <= '0;
          dst_y_q <= dst_y_q + 1'b1;
        end else begin
          dst_x_q <= dst_x_q + 1'b1;
        end
      end
      if (dst_hs)      wd_q <= '0;
      else if (active) wd_q <= wd_q + 1'b1;
    end
  end

  assign ac_crf_wrt   = (state_q == S_REPORT);
  assign ac_crf_waddr = ac_crf_wrt ? CRF_ADDR_WIDTH'(UPENDR_ADDR) : '0;
  assign ac_crf_wdata = ac_crf_wrt ? (err_q ? CRF_DATA_WIDTH'(2) : CRF_DATA_WIDTH'(1)) : '0;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = wr_done & ~err_q;
  assign err          = err_q;

endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Directed bench for upsp_frame_ctrl with a CRF-write scoreboard (SRC 4x2, DST 16x8, timeout 32).
module tb_upsp_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] crf_ac_UPSTR;
  logic        crf_ac_wbusy;
  logic        ac_crf_wrt;
  logic [31:0] ac_crf_waddr;
  logic [31:0] ac_crf_wdata;
  logic        src_valid_i, src_valid_o, src_rd_i;
  logic        dst_wrt_i, dst_wready_i, dst_wready_o;
  logic        busy, frame_done, err;

  always #5 clk = ~clk;

  upsp_frame_ctrl #(
    .CRF_DATA_WIDTH(32), .CRF_ADDR_WIDTH(32),
    .SRC_IMG_WIDTH(4), .SRC_IMG_HEIGHT(2),
    .DST_IMG_WIDTH(16), .DST_IMG_HEIGHT(8),
    .UPENDR_ADDR('h4), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .crf_ac_UPSTR(crf_ac_UPSTR), .crf_ac_wbusy(crf_ac_wbusy),
    .ac_crf_wrt(ac_crf_wrt), .ac_crf_waddr(ac_crf_waddr), .ac_crf_wdata(ac_crf_wdata),
    .src_valid_i(src_valid_i), .src_valid_o(src_valid_o), .src_rd_i(src_rd_i),
    .dst_wrt_i(dst_wrt_i), .dst_wready_i(dst_wready_i), .dst_wready_o(dst_wready_o),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];   // expected CRF writes, pushed at frame start
  wr_t obs_q[$];   // completed CRF writes seen on the bus
  wr_t hold_q[$];  // every cycle the write strobe is high
  int  n_src = 0, n_dst = 0, n_done = 0;
  int  n_tests = 0, n_fail = 0;
  int  obs_rd = 0;

  always @(negedge clk) begin
    if (src_valid_o && src_rd_i)   n_src  <= n_src + 1;
    if (dst_wrt_i && dst_wready_o) n_dst  <= n_dst + 1;
    if (frame_done)                n_done <= n_done + 1;
    if (ac_crf_wrt) hold_q.push_back({ac_crf_waddr, ac_crf_wdata});
    if (ac_crf_wrt && !crf_ac_wbusy) obs_q.push_back({ac_crf_waddr, ac_crf_wdata});
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed stuck, required $finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit expect_wr, input logic [31:0] exp_data);
    if (expect_wr) exp_q.push_back({32'h4, exp_data});
    crf_ac_UPSTR = 32'h0;
    tick();
    crf_ac_UPSTR = 32'h1;
    tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic drain_sb();
    wr_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        chk("wr_addr", obs_q[obs_rd].addr, e.addr);
        chk("wr_data", obs_q[obs_rd].data, e.data);
        obs_rd++;
      end else begin
        chk("wr_missing", obs_q.size(), obs_rd + 1);
      end
    end
    chk("wr_extra", obs_q.size(), obs_rd);
  endtask

  initial begin
    int s0, d0, f0, h0, o0, n, w;
    rst_n = 1'b0;
    crf_ac_UPSTR = 32'h0;
    crf_ac_wbusy = 1'b0;
    src_valid_i = 1'b1; src_rd_i = 1'b1;
    dst_wrt_i = 1'b1; dst_wready_i = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_wrt", ac_crf_wrt, 0);
    chk("rst_waddr", ac_crf_waddr, 0);
    chk("rst_wdata", ac_crf_wdata, 0);
    chk("rst_src_valid_o", src_valid_o, 0);
    chk("rst_dst_wready_o", dst_wready_o, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_gate", src_valid_o, 0);

    // nominal frame, continuous flow
    s0 = n_src; d0 = n_dst; f0 = n_done;
    start_frame(1'b1, 32'h1);
    chk("nom_busy", busy, 1);
    repeat (8) tick();
    chk("nom_src_gated", src_valid_o, 0);
    chk("nom_busy_drain", busy, 1);
    wait_idle(300);
    chk("nom_src_cnt", n_src - s0, 8);
    chk("nom_dst_cnt", n_dst - d0, 128);
    chk("nom_done_cnt", n_done - f0, 1);
    chk("nom_err", err, 0);
    drain_sb();

    // dst backpressure and CRF write stall
    crf_ac_wbusy = 1'b1;
    d0 = n_dst; f0 = n_done;
    start_frame(1'b1, 32'h1);
    h0 = hold_q.size();
    n = 0; w = 0;
    while (busy && n < 800) begin
      dst_wready_i = ~dst_wready_i;
      tick();
      n++;
      if (ac_crf_wrt) begin
        w++;
        if (w == 6) crf_ac_wbusy = 1'b0;
      end
    end
    dst_wready_i = 1'b1;
    crf_ac_wbusy = 1'b0;
    chk("bp_idle", busy, 0);
    chk("bp_dst_cnt", n_dst - d0, 128);
    chk("bp_hold_cycles", hold_q.size() - h0, 6);
    for (int i = h0; i < hold_q.size(); i++) begin
      chk("bp_hold_addr", hold_q[i].addr, 32'h4);
      chk("bp_hold_data", hold_q[i].data, 32'h1);
    end
    chk("bp_done_cnt", n_done - f0, 1);
    drain_sb();

    // timeout after 40 output beats
    d0 = n_dst; f0 = n_done;
    start_frame(1'b1, 32'h2);
    repeat (40) tick();
    dst_wrt_i = 1'b0;
    chk("to_dst_cnt", n_dst - d0, 40);
    n = 0;
    while (!ac_crf_wrt && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", n, 32);
    chk("to_wdata", ac_crf_wdata, 32'h2);
    chk("to_err", err, 1);
    chk("to_frame_done", frame_done, 0);
    tick();
    chk("to_idle", busy, 0);
    chk("to_err_sticky", err, 1);
    chk("to_done_cnt", n_done - f0, 0);
    drain_sb();
    dst_wrt_i = 1'b1;

    // restart clears err; a second start edge mid-frame is ignored
    s0 = n_src; d0 = n_dst; f0 = n_done;
    start_frame(1'b1, 32'h1);
    chk("restart_err_clr", err, 0);
    repeat (20) tick();
    crf_ac_UPSTR = 32'h0;
    tick();
    crf_ac_UPSTR = 32'h1;
    tick();
    chk("rs_busy", busy, 1);
    wait_idle(300);
    chk("rs_src_cnt", n_src - s0, 8);
    chk("rs_dst_cnt", n_dst - d0, 128);
    chk("rs_done_cnt", n_done - f0, 1);
    drain_sb();

    // async reset mid-frame, then a clean frame
    d0 = n_dst;
    start_frame(1'b0, 32'h0);
    repeat (50) tick();
    chk("mr_dst_cnt", n_dst - d0, 50);
    o0 = obs_q.size();
    rst_n = 1'b0;
    crf_ac_UPSTR = 32'h0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_wrt", ac_crf_wrt, 0);
    chk("mr_dst_wready_o", dst_wready_o, 0);
    chk("mr_src_valid_o", src_valid_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_write", obs_q.size(), o0);
    d0 = n_dst; f0 = n_done;
    start_frame(1'b1, 32'h1);
    wait_idle(300);
    chk("mr_full_dst_cnt", n_dst - d0, 128);
    chk("mr_done_cnt", n_done - f0, 1);
    drain_sb();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
